// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data bus: TXDATA/STATUS window,
// byte FIFO feeding a serializer, registered load data with RV32I load extension.
`timescale 1ns/1ps
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        rd_hit,
    output logic        tx,
    output logic        tx_busy
);

    localparam int IDX_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                rd_hit_q, rd_hit_d;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [7:0]          fifo_head;
    logic [PTR_W-1:0]    count;
    logic [2:0]          count_sat;
    logic                empty, full;
    logic                hit, wr_data, wr_status, push, pop, ovf_evt, ovf_clr;
    logic [31:0]         status_word, win_word, ext_word;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic                unused_wdata;

    assign unused_wdata = ^{WriteData[31:8]};

    assign hit       = (Adr[31:3] == BASE_ADDR[31:3]);
    assign wr_data   = MemWrite && hit && !Adr[2];
    assign wr_status = MemWrite && hit && Adr[2];
    assign tx_busy   = (state_q != ST_IDLE);
    assign tx        = tx_q;
    assign ReadData  = read_data_q;
    assign rd_hit    = rd_hit_q;
    assign fifo_head = fifo_mem[rptr_q[IDX_W-1:0]];

    // FIFO occupancy from pointers that carry one extra wrap bit
    always_comb begin
        count = wptr_q - rptr_q;
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
        if (32'(count) > 32'd7) begin
            count_sat = 3'd7;
        end else begin
            count_sat = 3'(count);
        end
    end

    always_comb begin
        push    = wr_data && (!full || pop);
        ovf_evt = wr_data && full && !pop;
        ovf_clr = wr_status && WriteData[3];
        wptr_d  = wptr_q + PTR_W'(push);
        rptr_d  = rptr_q + PTR_W'(pop);
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = BAUD_MAX;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    baud_d    = BAUD_MAX;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit so frames have no gap
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        baud_d  = BAUD_MAX;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        status_word = {25'd0, count_sat, ovf_q, tx_busy, empty, full};
        win_word    = (hit && Adr[2]) ? status_word : 32'd0;
        case (Adr[1:0])
            2'd0:    sel_byte = win_word[7:0];
            2'd1:    sel_byte = win_word[15:8];
            2'd2:    sel_byte = win_word[23:16];
            default: sel_byte = win_word[31:24];
        endcase
        sel_half = Adr[1] ? win_word[31:16] : win_word[15:0];
        case (funct3)
            3'b000:  ext_word = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ext_word = {24'd0, sel_byte};
            3'b001:  ext_word = {{16{sel_half[15]}}, sel_half};
            3'b101:  ext_word = {16'd0, sel_half};
            3'b010:  ext_word = win_word;
            default: ext_word = 32'd0;
        endcase
        read_data_d = hit ? ext_word : 32'd0;
        rd_hit_d    = hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            tx_q        <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ovf_q       <= 1'b0;
            read_data_q <= 32'd0;
            rd_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ovf_q       <= ovf_d;
            read_data_q <= read_data_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    // Payload storage needs no reset; validity is carried by the pointers and state
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) begin
            fifo_mem[wptr_q[IDX_W-1:0]] <= WriteData[7:0];
        end
    end

endmodule
